// File: rtl/muntjac_fpu_round_pack.sv
// Round-and-pack stage for the Muntjac FPU: rounds a sticky-shifted significand and packs an
// IEEE result with exception flags. Define MUNTJAC_FPU_ROUND_PACK_STAGE2_EN for a 2-stage pipe.
module muntjac_fpu_round_pack #(
  parameter int unsigned ExpWidth = 8,
  parameter int unsigned SigWidth = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [2:0]                   rm_i,
  input  logic                         sign_i,
  input  logic [ExpWidth:0]            exp_i,
  input  logic [SigWidth+1:0]          sig_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [ExpWidth+SigWidth-1:0] result_o,
  output logic [4:0]                   fflags_o
);

  localparam logic [ExpWidth+1:0] ExpMax = {2'b00, {ExpWidth{1'b1}}};

  // Round-up decision and increment
  logic              lsb, rnd, stk, round_up;
  logic [SigWidth:0] s1_sig_d;

  always_comb begin
    lsb = sig_i[2];
    rnd = sig_i[1];
    stk = sig_i[0];
    case (rm_i)
      3'd1:    round_up = 1'b0;
      3'd2:    round_up = sign_i & (rnd | stk);
      3'd3:    round_up = ~sign_i & (rnd | stk);
      3'd4:    round_up = rnd;
      default: round_up = rnd & (stk | lsb);
    endcase
    s1_sig_d = {1'b0, sig_i[SigWidth+1:2]} + {{SigWidth{1'b0}}, round_up};
  end

  // Pack inputs: stage-1 registers when pipelined, the live rounding result when merged
  logic                         pk_sign;
  logic [ExpWidth:0]            pk_exp;
  logic [SigWidth:0]            pk_sig;
  logic                         pk_inexact;
  logic [2:0]                   pk_rm;
  logic [ExpWidth+SigWidth-1:0] pk_result;
  logic [4:0]                   pk_fflags;

  logic                  carry, hidden, of, uf, nx, to_inf;
  logic [ExpWidth+1:0]   exp_adj;
  logic [ExpWidth-1:0]   exp_field;
  logic [SigWidth-2:0]   frac;

  always_comb begin
    carry     = pk_sig[SigWidth];
    hidden    = pk_sig[SigWidth] | pk_sig[SigWidth-1];
    exp_adj   = {1'b0, pk_exp} + {{(ExpWidth+1){1'b0}}, carry};
    of        = (exp_adj >= ExpMax);
    exp_field = hidden ? exp_adj[ExpWidth-1:0] : '0;
    frac      = carry ? '0 : pk_sig[SigWidth-2:0];
    case (pk_rm)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = pk_sign;
      3'd3:    to_inf = ~pk_sign;
      default: to_inf = 1'b1;
    endcase
    if (of) begin
      if (to_inf) begin
        exp_field = '1;
        frac      = '0;
      end else begin
        exp_field = {{(ExpWidth-1){1'b1}}, 1'b0};
        frac      = '1;
      end
    end
    // Tininess is detected after rounding
    uf        = (exp_field == '0) & pk_inexact;
    nx        = pk_inexact | of;
    pk_result = {pk_sign, exp_field, frac};
    pk_fflags = {2'b00, of, uf, nx};
  end

  logic                         out_valid_q;
  logic [ExpWidth+SigWidth-1:0] result_q;
  logic [4:0]                   fflags_q;

`ifdef MUNTJAC_FPU_ROUND_PACK_STAGE2_EN
  logic                s1_valid_q, s1_sign_q, s1_inexact_q;
  logic [ExpWidth:0]   s1_exp_q;
  logic [SigWidth:0]   s1_sig_q;
  logic [2:0]          s1_rm_q;
  logic                s2_ready, s1_adv;

  assign s2_ready   = ~out_valid_q | out_ready_i;
  assign s1_adv     = s1_valid_q & s2_ready;
  assign in_ready_o = ~s1_valid_q | s1_adv;

  assign pk_sign    = s1_sign_q;
  assign pk_exp     = s1_exp_q;
  assign pk_sig     = s1_sig_q;
  assign pk_inexact = s1_inexact_q;
  assign pk_rm      = s1_rm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_sig_q     <= '0;
      s1_inexact_q <= 1'b0;
      s1_rm_q      <= '0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      fflags_q     <= '0;
    end else if (flush_i) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_ready_o) s1_valid_q <= in_valid_i;
      if (in_valid_i && in_ready_o) begin
        s1_sign_q    <= sign_i;
        s1_exp_q     <= exp_i;
        s1_sig_q     <= s1_sig_d;
        s1_inexact_q <= sig_i[1] | sig_i[0];
        s1_rm_q      <= rm_i;
      end
      if (s2_ready) out_valid_q <= s1_valid_q;
      if (s1_adv) begin
        result_q <= pk_result;
        fflags_q <= pk_fflags;
      end
    end
  end
`else
  assign in_ready_o = ~out_valid_q | out_ready_i;

  assign pk_sign    = sign_i;
  assign pk_exp     = exp_i;
  assign pk_sig     = s1_sig_d;
  assign pk_inexact = sig_i[1] | sig_i[0];
  assign pk_rm      = rm_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      fflags_q    <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else begin
      if (in_ready_o) out_valid_q <= in_valid_i;
      if (in_valid_i && in_ready_o) begin
        result_q <= pk_result;
        fflags_q <= pk_fflags;
      end
    end
  end
`endif

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign fflags_o    = fflags_q;

endmodule

// File: tb/tb_muntjac_fpu_round_pack.sv
// Scoreboard bench for muntjac_fpu_round_pack (ExpWidth=8, SigWidth=24), directed vectors.
module tb_muntjac_fpu_round_pack;

  logic        clk, rst_n, flush, in_valid, in_ready, sign, out_valid, out_ready;
  logic [2:0]  rm;
  logic [8:0]  exp_in;
  logic [25:0] sig_in;
  logic [31:0] result;
  logic [4:0]  fflags;

  muntjac_fpu_round_pack #(.ExpWidth(8), .SigWidth(24)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .rm_i       (rm),
    .sign_i     (sign),
    .exp_i      (exp_in),
    .sig_i      (sig_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .fflags_o   (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [8:0]  e;
    logic [25:0] sg;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [7:0]  id;
  } exp_t;

  localparam int NumVec = 18;
  vec_t vecs [NumVec];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    vecs = '{
      '{1'b0, 9'd127, 26'h2000002, 3'd0, 32'h3F800000, 5'h01},  // round-bit tie, even lsb
      '{1'b0, 9'd127, 26'h3FFFFFE, 3'd0, 32'h40000000, 5'h01},  // carry out
      '{1'b0, 9'd254, 26'h3FFFFFE, 3'd0, 32'h7F800000, 5'h05},  // overflow to inf
      '{1'b0, 9'd255, 26'h3FFFFFE, 3'd1, 32'h7F7FFFFF, 5'h05},  // RTZ overflow -> max finite
      '{1'b0, 9'd1,   26'h1FFFFFF, 3'd0, 32'h00800000, 5'h01},  // subnormal rounds to normal
      '{1'b0, 9'd1,   26'h1FFFFFF, 3'd1, 32'h007FFFFF, 5'h03},  // tiny inexact
      '{1'b0, 9'd127, 26'h2000000, 3'd0, 32'h3F800000, 5'h00},  // exact
      '{1'b1, 9'd127, 26'h2000001, 3'd2, 32'hBF800001, 5'h01},  // RDN negative rounds up
      '{1'b0, 9'd127, 26'h2000001, 3'd2, 32'h3F800000, 5'h01},  // RDN positive truncates
      '{1'b0, 9'd127, 26'h2000001, 3'd3, 32'h3F800001, 5'h01},  // RUP positive
      '{1'b0, 9'd127, 26'h2000002, 3'd4, 32'h3F800001, 5'h01},  // RMM tie away
      '{1'b0, 9'd127, 26'h2000006, 3'd0, 32'h3F800002, 5'h01},  // RNE tie, odd lsb
      '{1'b0, 9'd127, 26'h2000006, 3'd5, 32'h3F800002, 5'h01},  // rm 5 acts as RNE
      '{1'b1, 9'd254, 26'h3FFFFFE, 3'd2, 32'hFF800000, 5'h05},  // RDN negative -> -inf
      '{1'b1, 9'd255, 26'h2000000, 3'd3, 32'hFF7FFFFF, 5'h05},  // RUP negative -> -max
      '{1'b0, 9'd1,   26'h0000004, 3'd0, 32'h00000001, 5'h00},  // exact subnormal
      '{1'b0, 9'd1,   26'h0000000, 3'd0, 32'h00000000, 5'h00},  // zero
      '{1'b0, 9'd254, 26'h3FFFFFE, 3'd4, 32'h7F800000, 5'h05}   // RMM overflow
    };
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive one vector and wait (bounded) for acceptance; caller is at posedge+1
  task automatic send(input int idx);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    sign     = vecs[idx].s;
    exp_in   = vecs[idx].e;
    sig_in   = vecs[idx].sg;
    rm       = vecs[idx].rm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) begin
      exp_q.push_back('{res: vecs[idx].res, fl: vecs[idx].fl, id: 8'(idx)});
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: vec%0d got in_ready 0 required 1", idx);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop on each output transfer, check hold-stability while stalled
  initial begin
    exp_t        e;
    logic        held_v;
    logic [36:0] held;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got %h/%h required no output", result, fflags);
          end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({result, fflags} !== {e.res, e.fl}) begin
              n_err++;
              $display("FAIL vec%0d: got result %h fflags %h required result %h fflags %h",
                       e.id, result, fflags, e.res, e.fl);
            end
          end
          held_v = 1'b0;
        end else begin
          if (held_v) begin
            n_cmp++;
            if ({result, fflags} !== held) begin
              n_err++;
              $display("FAIL hold_stable: got %h required %h", {result, fflags}, held);
            end
          end
          held_v = 1'b1;
          held   = {result, fflags};
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign      = 1'b0;
    rm        = '0;
    exp_in    = '0;
    sig_in    = '0;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Latency
    send(0);
`ifdef MUNTJAC_FPU_ROUND_PACK_STAGE2_EN
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
`endif
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    drain();

    // Full-throughput stream of all vectors
    for (int i = 0; i < NumVec; i++) send(i);
    drain();

    // Downstream stall with three back-to-back inputs
    out_ready = 1'b0;
    fork
      begin
        send(1);
        send(4);
        send(5);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two operations in flight and a simultaneous input that must be dropped
    send(2);
    send(3);
    out_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    sign      = vecs[6].s;
    exp_in    = vecs[6].e;
    sig_in    = vecs[6].sg;
    rm        = vecs[6].rm;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_no_stale", 32'(out_valid), 32'd0);

    // Asynchronous reset with two operations in flight
    send(7);
    send(10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_fflags", 32'(fflags), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_stale", 32'(out_valid), 32'd0);

    // Operation resumes after reset
    send(11);
    send(13);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
